// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART byte queue.
package uart_pkg;

  localparam int DEPTH_DEF   = 16;
  localparam int GAP_DEF     = 4;
  localparam int TIMEOUT_DEF = 4096;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

endpackage

// File: rtl/byte_fifo.sv
// Circular byte store with wrapping pointers and an occupancy counter.
module byte_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          full,
  output logic [AW:0]   count,
  output logic          drop
);

  localparam logic [AW:0] FULL_N = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_rd;
  logic          do_wr;

  // a pop in the same cycle frees the slot a full-queue write needs
  assign do_rd   = rd_en && (count != '0);
  assign do_wr   = wr_en && (!full || do_rd);
  assign drop    = wr_en && full && !do_rd;
  assign full    = (count == FULL_N);
  assign rd_data = mem[rptr];

  always_ff @(posedge clk) begin
    if (!rst && do_wr) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      if (do_wr && !do_rd) count <= count + 1'b1;
      else if (do_rd && !do_wr) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/uart_byte_queue.sv
// Byte queue feeding uart_tx: pops, strobes tx_start, waits for
// tx_done with a timeout, then idles for a gap before the next byte.
module uart_byte_queue
  import uart_pkg::*;
#(
  parameter int DEPTH          = DEPTH_DEF,
  parameter int GAP_CYCLES     = GAP_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                     clk_3125KHz,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     tx_start,
  output logic [7:0]               msg,
  input  logic                     tx_done,
  output logic                     overflow,
  output logic                     tx_timeout
);

  localparam int GW = $clog2(GAP_CYCLES + 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  // a zero gap still spends one cycle in GAP
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    state;
  logic [GW-1:0] gcnt;
  logic [TW-1:0] tcnt;
  logic          pop;
  logic          drop;
  logic [7:0]    head;

  assign pop = (state == S_IDLE) && (count != '0);

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk_3125KHz),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .count   (count),
    .drop    (drop)
  );

  always_ff @(posedge clk_3125KHz) begin
    if (rst) begin
      state      <= S_IDLE;
      tx_start   <= 1'b0;
      msg        <= 8'h00;
      overflow   <= 1'b0;
      tx_timeout <= 1'b0;
      gcnt       <= '0;
      tcnt       <= '0;
    end else begin
      tx_start <= 1'b0;
      if (drop) overflow <= 1'b1;
      case (state)
        S_IDLE: begin
          if (pop) begin
            msg   <= head;
            state <= S_LOAD;
          end
        end
        S_LOAD: state <= S_START;
        S_START: begin
          tx_start <= 1'b1;
          tcnt     <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (tx_done) begin
            gcnt  <= '0;
            state <= S_GAP;
          end else if (tcnt == TO_LAST) begin
            tx_timeout <= 1'b1;
            gcnt       <= '0;
            state      <= S_GAP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_GAP: begin
          if (gcnt == GAP_LAST) state <= S_IDLE;
          else gcnt <= gcnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_queue.sv
// Directed and randomized bench for uart_byte_queue, scored against
// an ordered byte list and cycle-count timing rules.
module tb_uart_byte_queue;

  localparam int G       = 4;
  localparam int TO      = 4096;
  localparam int GAP_LEN = (G == 0) ? 1 : G;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic [4:0] count;
  logic       tx_start;
  logic [7:0] msg;
  logic       tx_done;
  logic       overflow;
  logic       tx_timeout;

  always #5 clk = ~clk;

  uart_byte_queue dut (
    .clk_3125KHz (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .count       (count),
    .tx_start    (tx_start),
    .msg         (msg),
    .tx_done     (tx_done),
    .overflow    (overflow),
    .tx_timeout  (tx_timeout)
  );

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         start_cnt = 0;
  int         last_start = -1;
  int         last_done = -1;
  int         done_at = -1;
  int         auto_delay = -1;
  bit         auto_rand = 0;
  bit         exact_gap = 0;
  bit         inflight = 0;
  logic [7:0] cur_msg = 8'h00;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (inflight && tx_start !== 1'b1) chk("msg_hold", msg, cur_msg);
    if (tx_start === 1'b1) begin
      if (last_start >= 0)
        chk("start_spacing", 32'(cyc - last_start >= G + 3), 1);
      if (exact_gap && last_start >= 0 && last_done > last_start)
        chk("gap_timing", cyc - last_done, GAP_LEN + 4);
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL start_no_data got=%0h exp=none", msg);
      end
      if (exp_q.size() > 0) chk("msg_order", msg, exp_q.pop_front());
      cur_msg    = msg;
      inflight   = 1;
      start_cnt++;
      last_start = cyc;
      if (auto_rand) done_at = cyc + $urandom_range(0, 8);
      else if (auto_delay >= 0) done_at = cyc + auto_delay;
    end
    tx_done = (cyc == done_at);
    if (tx_done) begin
      done_at   = -1;
      last_done = cyc;
      inflight  = 0;
    end
  endtask

  task automatic wr(input logic [7:0] b, input bit keep);
    wr_en   = 1'b1;
    wr_data = b;
    if (keep) exp_q.push_back(b);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_starts(input int target, input int bound);
    int k = 0;
    while (start_cnt < target && k < bound) begin
      tick();
      k++;
    end
    chk("wait_start", 32'(start_cnt >= target), 1);
  endtask

  logic [7:0] burst [7];
  int w;
  int d;
  int s;
  int n0;
  int n1;

  initial begin
    burst = '{"P", "M", "1", "-", "R", "-", "#"};
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; tx_done = 1'b0;
    tick();
    tick();
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_msg", msg, 8'h00);
    chk("rst_overflow", overflow, 0);
    chk("rst_timeout", tx_timeout, 0);
    rst = 1'b0;
    tick();

    // single byte latency, then gap-bounded return to IDLE
    exact_gap = 1; auto_delay = 10; last_start = -1;
    w = cyc;
    wr(8'h50, 1);
    wr(8'h51, 1);
    wait_starts(1, 20);
    chk("latency", last_start - w, 4);
    chk("msg_P", cur_msg, 8'h50);
    wait_starts(2, 60);
    chk("done_to_start", last_start - last_done, GAP_LEN + 4);
    repeat (30) tick();

    // burst message with an auto-responding uart_tx
    auto_rand = 1; last_start = -1;
    n0 = start_cnt;
    foreach (burst[i]) wr(burst[i], 1);
    wait_starts(n0 + 7, 400);
    repeat (40) tick();
    chk("burst_count", count, 0);
    exact_gap = 0; auto_rand = 0;

    // fill to full with tx_done withheld, then overflow
    auto_delay = -1;
    n0 = start_cnt;
    for (int i = 0; i < 16; i++) wr(8'hA0 + 8'(i), 1);
    chk("full_16w", full, 0);
    wr(8'hB0, 1);
    chk("full_17w", full, 1);
    chk("count_17w", count, 16);
    chk("no_ovf_yet", overflow, 0);
    wr(8'hEE, 0);
    chk("overflow", overflow, 1);
    chk("count_after_drop", count, 16);

    // write into the pop cycle while full
    d = cyc + 1;
    done_at = d;
    while (cyc < d + 5) tick();
    wr(8'hCC, 1);
    chk("rw_full_count", count, 16);
    chk("rw_full_flag", full, 1);
    auto_delay = 5;
    wait_starts(n0 + 18, 2000);
    repeat (50) tick();
    chk("drain_total", start_cnt - n0, 18);
    chk("drain_count", count, 0);

    // timeout then normal send
    auto_delay = -1;
    n0 = start_cnt;
    wr(8'h54, 1);
    wait_starts(n0 + 1, 20);
    s = last_start;
    while (cyc < s + TO - 1) tick();
    chk("timeout_before", tx_timeout, 0);
    tick();
    chk("timeout_set", tx_timeout, 1);
    inflight = 0;
    auto_delay = 3;
    wr(8'h55, 1);
    wait_starts(n0 + 2, 40);
    chk("after_to_msg", cur_msg, 8'h55);
    chk("timeout_sticky", tx_timeout, 1);
    repeat (30) tick();

    // reset while waiting for tx_done, then a stale tx_done
    auto_delay = -1;
    n0 = start_cnt;
    wr(8'h77, 1);
    wait_starts(n0 + 1, 20);
    repeat (3) tick();
    inflight = 0;
    rst = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
    tick();
    rst = 1'b0; wr_en = 1'b0;
    exp_q.delete();
    chk("r2_count", count, 0);
    chk("r2_full", full, 0);
    chk("r2_tx_start", tx_start, 0);
    chk("r2_msg", msg, 8'h00);
    chk("r2_overflow", overflow, 0);
    chk("r2_timeout", tx_timeout, 0);
    tx_done = 1'b1;
    n1 = start_cnt;
    tick();
    repeat (30) tick();
    chk("no_spurious_start", start_cnt, n1);
    chk("stale_done_count", count, 0);
    auto_delay = 2;
    w = cyc;
    wr(8'h21, 1);
    wait_starts(n1 + 1, 20);
    chk("latency_after_rst", last_start - w, 4);
    repeat (20) tick();

    // random traffic with random tx_done latency
    auto_rand = 1;
    repeat (300) begin
      if (!full && $urandom_range(0, 2) == 0) wr(8'($urandom), 1);
      else tick();
    end
    begin
      int k = 0;
      while (exp_q.size() > 0 && k < 2000) begin
        tick();
        k++;
      end
    end
    chk("rand_drained", exp_q.size(), 0);
    repeat (40) tick();
    chk("rand_count", count, 0);
    chk("rand_overflow", overflow, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_byte_queue.md
UART_BYTE_QUEUE -- requirements
Module: uart_byte_queue

Interface
REQ-001 Parameter DEPTH, default 16, sets the FIFO depth in bytes; it SHALL be a power of two, 4..64.
REQ-002 Parameter GAP_CYCLES, default 4, sets the idle clk_3125KHz cycles inserted between consecutive bytes sent to uart_tx.
REQ-003 Parameter TIMEOUT_CYCLES, default 4096, sets the maximum cycles to wait for tx_done after tx_start.
REQ-004 clk_3125KHz  input  1  sole clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 wr_en  input  1  producer write strobe, one byte per cycle.
REQ-007 wr_data  input  8  producer byte (ASCII message character).
REQ-008 full  output  1  high when the FIFO holds DEPTH bytes.
REQ-009 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-010 tx_start  output  1  one-cycle start pulse to uart_tx.
REQ-011 msg  output  8  byte presented to uart_tx.
REQ-012 tx_done  input  1  one-cycle completion pulse from uart_tx.
REQ-013 overflow  output  1  sticky flag: a write was dropped because the FIFO was full.
REQ-014 tx_timeout  output  1  sticky flag: tx_done did not arrive within TIMEOUT_CYCLES.

Function
REQ-015 The FIFO SHALL be circular, with read and write pointers that wrap modulo DEPTH and a separate occupancy counter.
REQ-016 A write with wr_en=1 and full=0 SHALL store wr_data at the write pointer and make it visible in count on the next cycle.
REQ-017 A write with wr_en=1 and full=1 SHALL be discarded, set overflow, and leave FIFO contents and pointers unchanged.
REQ-018 A write and a pop in the same cycle SHALL both take effect, leaving count unchanged; when full, the pop frees the slot before the write is evaluated.
REQ-019 The FSM SHALL have the states IDLE, LOAD, START, WAIT_DONE and GAP.
REQ-020 IDLE: when count>0, pop the head byte into the msg register and go to LOAD; otherwise stay in IDLE.
REQ-021 LOAD: hold msg for one cycle of setup, then go to START.
REQ-022 START: assert tx_start for exactly one cycle, clear the timeout counter, then go to WAIT_DONE.
REQ-023 WAIT_DONE: hold msg stable.
REQ-024 WAIT_DONE: on tx_done=1, go to GAP.
REQ-025 WAIT_DONE: if the timeout counter reaches TIMEOUT_CYCLES-1 without tx_done, set tx_timeout and go to GAP; the byte is not retried.
REQ-026 GAP: count GAP_CYCLES cycles, then go to IDLE; with GAP_CYCLES=0, GAP SHALL last exactly one cycle.
REQ-027 tx_done outside WAIT_DONE SHALL be ignored.
REQ-028 Latency from the first write into an empty, idle queue to tx_start SHALL be exactly 4 cycles (write, IDLE pop, LOAD, START).
REQ-029 msg SHALL change only on a pop in IDLE.
REQ-030 Bytes SHALL leave the queue in write order with no duplication.
REQ-031 full SHALL equal (count==DEPTH) and be registered-consistent with count in every cycle.

Reset
REQ-032 On rst=1, all of the following SHALL be cleared at the next edge: FSM to IDLE, pointers=0, count=0, full=0, tx_start=0, msg=8'h00, overflow=0, tx_timeout=0, gap and timeout counters=0.
REQ-033 rst SHALL take priority over wr_en and tx_done in the same cycle.
REQ-034 A reset during WAIT_DONE SHALL abandon the byte in flight without asserting tx_start again.
REQ-035 A tx_done arriving after such a reset SHALL be ignored.

Structure
REQ-036 Shared package uart_pkg SHALL hold the FSM state encoding and default constants DEPTH_DEF=16, GAP_DEF=4, TIMEOUT_DEF=4096.
REQ-037 The storage SHALL be one sub-module, byte_fifo (memory, pointers, count, full).
REQ-038 The FSM and counters SHALL reside in uart_byte_queue.

Verification
REQ-039 Reset, then write 8'h50 ('P'); with tx_done returned 10 cycles after tx_start: tx_start fires 4 cycles after the write, msg=8'h50, and the FSM returns to IDLE GAP_CYCLES cycles after tx_done.
REQ-040 Burst-write "PM1-R-#" (7 bytes) with an auto-responding tx_done model: the bytes emerge in order, each tx_start is separated by at least GAP_CYCLES+3 cycles, and count ends at 0.
REQ-041 With the default DEPTH=16 and tx_done withheld, write 18 bytes: full=1 after 17 writes (16 queued plus 1 in flight), the 18th write sets overflow=1, and releasing tx_done drains exactly 17 bytes.
REQ-042 With the queue full, write and pop in the same cycle: count stays at 16 and the new byte appears last.
REQ-043 Never assert tx_done after tx_start: tx_timeout=1 after 4096 cycles, and the next byte is still sent normally.
REQ-044 Assert rst in WAIT_DONE, then pulse tx_done: all outputs return to their reset values, no spurious tx_start occurs, and the stale tx_done has no effect.
